// File: rtl/wheel_step_decoder_pkg.sv
// wheel_step_decoder_pkg: phase codes, bin_speed layout and magnitude codes shared by the stepper drive and decoder.
package wheel_step_decoder_pkg;
    localparam logic [3:0] PH_IDLE = 4'b0000;
    localparam logic [3:0] PH_0    = 4'b0001;
    localparam logic [3:0] PH_1    = 4'b0010;
    localparam logic [3:0] PH_2    = 4'b0100;
    localparam logic [3:0] PH_3    = 4'b1000;
    localparam int DIR_BIT = 2;
    localparam int MAG_MSB = 1;
    localparam int MAG_LSB = 0;
    localparam logic [1:0] MAG_STOP = 2'd0;
    localparam logic [1:0] MAG_SLOW = 2'd1;
    localparam logic [1:0] MAG_MED  = 2'd2;
    localparam logic [1:0] MAG_FAST = 2'd3;
    typedef enum logic {IDLE, TRACK} state_t;
    // Index of a one-hot phase; meaningless for other patterns.
    function automatic logic [1:0] ph_idx(input logic [3:0] p);
        return {p[3] | p[2], p[3] | p[1]};
    endfunction
endpackage

// File: rtl/wheel_step_decoder_if.sv
// wheel_step_decoder_if: stepper phase lines in, decoded motion out.
interface wheel_step_decoder_if;
    logic       sem0;
    logic       sem1;
    logic       sem2;
    logic       sem3;
    logic [7:0] tick_count;
    logic [2:0] bin_speed;
    logic       direction;
    logic       step_valid;
    logic       phase_error;
    modport master (
        output sem0, sem1, sem2, sem3,
        input  tick_count, bin_speed, direction, step_valid, phase_error
    );
    modport slave (
        input  sem0, sem1, sem2, sem3,
        output tick_count, bin_speed, direction, step_valid, phase_error
    );
endinterface

// File: rtl/wheel_step_decoder_step_period_meter.sv
// step_period_meter: saturating inter-step period counter, capture, timeout and speed quantiser.
module step_period_meter
    import wheel_step_decoder_pkg::*;
#(
    parameter int CNT_W   = 24,
    parameter int P_FAST  = 50000,
    parameter int P_MED   = 100000,
    parameter int P_SLOW  = 200000,
    parameter int TIMEOUT = 400000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_step,
    input  logic       i_first,
    input  logic       i_clear,
    input  logic       i_stop,
    input  logic       i_dir,
    output logic [2:0] o_bin_speed
);
    localparam logic [CNT_W-1:0] L_FAST    = CNT_W'(P_FAST);
    localparam logic [CNT_W-1:0] L_MED     = CNT_W'(P_MED);
    localparam logic [CNT_W-1:0] L_SLOW    = CNT_W'(P_SLOW);
    localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] L_MAX     = '1;
    logic [CNT_W-1:0] r_cnt, r_cap, w_cnt_next;
    logic             r_pend, r_first, r_dir, w_timeout;
    logic [1:0]       r_mag, w_mag;
    always_comb begin
        w_cnt_next = i_clear ? '0 : i_step ? CNT_W'(1) : r_cnt == L_MAX ? r_cnt : r_cnt + 1'b1;
        w_timeout  = !i_step && w_cnt_next == L_TIMEOUT;
        w_mag      = r_first ? (r_cap <= L_SLOW ? MAG_SLOW : MAG_STOP) :
                     r_cap <= L_FAST ? MAG_FAST :
                     r_cap <= L_MED  ? MAG_MED  :
                     r_cap <= L_SLOW ? MAG_SLOW : MAG_STOP;
    end
    // The capture lands on the step edge; the quantised code follows one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_cap   <= '0;
            r_pend  <= 1'b0;
            r_first <= 1'b0;
            r_dir   <= 1'b0;
            r_mag   <= MAG_STOP;
        end else begin
            r_cnt  <= w_cnt_next;
            r_pend <= i_step;
            if (i_step) begin
                r_cap   <= r_cnt;
                r_first <= i_first;
            end
            r_dir <= r_pend ? i_dir : r_dir;
            r_mag <= (i_stop || w_timeout) ? MAG_STOP : r_pend ? w_mag : r_mag;
        end
    end
    assign o_bin_speed[DIR_BIT]         = r_dir;
    assign o_bin_speed[MAG_MSB:MAG_LSB] = r_mag;
endmodule

// File: rtl/wheel_step_decoder.sv
// wheel_step_decoder: decodes wave-drive stepper phases into step count, direction and speed code.
module wheel_step_decoder
    import wheel_step_decoder_pkg::*;
#(
    parameter int CNT_W   = 24,
    parameter int P_FAST  = 50000,
    parameter int P_MED   = 100000,
    parameter int P_SLOW  = 200000,
    parameter int TIMEOUT = 400000
) (
    input logic           clk,
    input logic           rst,
    wheel_step_decoder_if.slave bus
);
    logic [3:0] r_s1, r_s2;
    state_t     r_state, w_state_next;
    logic [1:0] r_idx, w_idx, w_idx_next;
    logic [7:0] r_tick;
    logic       r_direction, r_step_valid, r_phase_error, r_first;
    logic       w_onehot, w_rev, w_skip, w_step, w_err, w_arm, w_stop;
    logic [2:0] w_bin_speed;
    always_comb begin
        w_onehot     = r_s2 != PH_IDLE && (r_s2 & (r_s2 - 4'd1)) == 4'd0;
        w_idx        = ph_idx(r_s2);
        w_rev        = w_idx == r_idx - 2'd1;
        w_skip       = w_idx == r_idx + 2'd2;
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_step       = 1'b0;
        w_err        = 1'b0;
        w_arm        = 1'b0;
        w_stop       = 1'b0;
        if (r_state == IDLE) begin
            w_arm        = w_onehot;
            w_err        = !w_onehot && r_s2 != PH_IDLE;
            w_state_next = w_onehot ? TRACK : IDLE;
            w_idx_next   = w_onehot ? w_idx : r_idx;
        end else if (!w_onehot) begin
            w_state_next = IDLE;
            w_stop       = 1'b1;
            w_err        = r_s2 != PH_IDLE;
        end else if (w_idx != r_idx) begin
            w_idx_next = w_idx;
            w_step     = !w_skip;
            w_err      = w_skip;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1          <= '0;
            r_s2          <= '0;
            r_state       <= IDLE;
            r_idx         <= '0;
            r_tick        <= '0;
            r_direction   <= 1'b0;
            r_step_valid  <= 1'b0;
            r_phase_error <= 1'b0;
            r_first       <= 1'b0;
        end else begin
            r_s1          <= {bus.sem3, bus.sem2, bus.sem1, bus.sem0};
            r_s2          <= r_s1;
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_step_valid  <= w_step;
            r_phase_error <= w_err;
            r_first       <= w_arm ? 1'b1 : w_step ? 1'b0 : r_first;
            if (w_step) begin
                r_direction <= w_rev;
                r_tick      <= w_rev ? r_tick - 8'd1 : r_tick + 8'd1;
            end
        end
    end
    step_period_meter #(
        .CNT_W(CNT_W), .P_FAST(P_FAST), .P_MED(P_MED), .P_SLOW(P_SLOW), .TIMEOUT(TIMEOUT)
    ) u_meter (
        .clk(clk),
        .rst(rst),
        .i_step(w_step),
        .i_first(r_first),
        .i_clear(w_arm),
        .i_stop(w_stop),
        .i_dir(r_direction),
        .o_bin_speed(w_bin_speed)
    );
    assign bus.tick_count  = r_tick;
    assign bus.bin_speed   = w_bin_speed;
    assign bus.direction   = r_direction;
    assign bus.step_valid  = r_step_valid;
    assign bus.phase_error = r_phase_error;
endmodule

// File: tb/tb_wheel_step_decoder.sv
// tb_wheel_step_decoder: directed phase sequences with hand-computed expectations.
module tb_wheel_step_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    wheel_step_decoder_if b();
    wheel_step_decoder #(
        .P_FAST(10), .P_MED(20), .P_SLOW(40), .TIMEOUT(80)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic set_ph(input logic [3:0] p);
        {b.sem3, b.sem2, b.sem1, b.sem0} = p;
    endtask
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask
    // Phase changes at a falling edge appear as step_valid after the third rising edge.
    task automatic step(input logic [3:0] p, input int gap, input logic [7:0] tick_e,
                        input logic dir_e, input logic [2:0] bin_e);
        set_ph(p);
        wait_n(3);
        chk("step_valid", 8'(b.step_valid), 8'd1);
        chk("tick_count", b.tick_count, tick_e);
        chk("direction", 8'(b.direction), 8'(dir_e));
        wait_n(1);
        chk("step_pulse", 8'(b.step_valid), 8'd0);
        chk("bin_speed", 8'(b.bin_speed), 8'(bin_e));
        wait_n(gap - 4);
    endtask
    initial begin
        set_ph(4'b0000);
        wait_n(3);
        chk("rst_tick", b.tick_count, 8'd0);
        chk("rst_bin", 8'(b.bin_speed), 8'd0);
        chk("rst_dir", 8'(b.direction), 8'd0);
        chk("rst_sv", 8'(b.step_valid), 8'd0);
        chk("rst_pe", 8'(b.phase_error), 8'd0);
        rst = 1'b0;
        set_ph(4'b0001);
        wait_n(8);
        chk("arm_sv", 8'(b.step_valid), 8'd0);
        chk("arm_tick", b.tick_count, 8'd0);
        step(4'b0010, 8, 8'd1, 1'b0, 3'b001);
        step(4'b0100, 8, 8'd2, 1'b0, 3'b011);
        step(4'b1000, 8, 8'd3, 1'b0, 3'b011);
        step(4'b0001, 8, 8'd4, 1'b0, 3'b011);
        set_ph(4'b0000);
        rst = 1'b1;
        wait_n(2);
        rst = 1'b0;
        set_ph(4'b1000);
        wait_n(30);
        step(4'b0001, 30, 8'd1, 1'b0, 3'b001);
        step(4'b1000, 30, 8'd0, 1'b1, 3'b101);
        step(4'b0100, 30, 8'd255, 1'b1, 3'b101);
        step(4'b0010, 15, 8'd254, 1'b1, 3'b101);
        step(4'b0001, 4, 8'd253, 1'b1, 3'b110);
        wait_n(77);
        chk("pre_timeout_bin", 8'(b.bin_speed), 8'b110);
        wait_n(1);
        chk("timeout_bin", 8'(b.bin_speed), 8'b100);
        chk("timeout_tick", b.tick_count, 8'd253);
        wait_n(21);
        set_ph(4'b0100);
        wait_n(3);
        chk("skip_pe", 8'(b.phase_error), 8'd1);
        chk("skip_sv", 8'(b.step_valid), 8'd0);
        chk("skip_tick", b.tick_count, 8'd253);
        wait_n(1);
        chk("skip_pe_pulse", 8'(b.phase_error), 8'd0);
        wait_n(4);
        step(4'b1000, 8, 8'd254, 1'b0, 3'b000);
        step(4'b0001, 8, 8'd255, 1'b0, 3'b011);
        set_ph(4'b0011);
        wait_n(1);
        set_ph(4'b0010);
        wait_n(2);
        chk("illegal_pe", 8'(b.phase_error), 8'd1);
        chk("illegal_bin", 8'(b.bin_speed), 8'b000);
        chk("illegal_sv", 8'(b.step_valid), 8'd0);
        wait_n(1);
        chk("rearm_pe", 8'(b.phase_error), 8'd0);
        chk("rearm_sv", 8'(b.step_valid), 8'd0);
        wait_n(5);
        chk("rearm_tick", b.tick_count, 8'd255);
        step(4'b0100, 8, 8'd0, 1'b0, 3'b001);
        set_ph(4'b0010);
        wait_n(3);
        chk("pre_rst_sv", 8'(b.step_valid), 8'd1);
        chk("pre_rst_tick", b.tick_count, 8'd255);
        #2 rst = 1'b1;
        #1;
        chk("async_tick", b.tick_count, 8'd0);
        chk("async_bin", 8'(b.bin_speed), 8'd0);
        chk("async_dir", 8'(b.direction), 8'd0);
        chk("async_sv", 8'(b.step_valid), 8'd0);
        chk("async_pe", 8'(b.phase_error), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_sv", 8'(b.step_valid), 8'd0);
        end
        chk("post_rst_tick", b.tick_count, 8'd0);
        step(4'b0100, 8, 8'd1, 1'b0, 3'b001);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
